// File: rtl/fpu_add_pkg.sv
// Shared types for the FPU adder operand-select stage: data-class encoding, default widths,
// operand layout and the path-select helper.
package fpu_add_pkg;

    localparam int unsigned FPU_EXP_W = 8;
    localparam int unsigned FPU_MAN_W = 28;

    typedef enum logic [1:0] {
        SUBNOR  = 2'b00,
        NOR     = 2'b01,
        MIX     = 2'b10,
        SPECIAL = 2'b11
    } e_data_e;

    // Operand layout at the default widths; the top rebuilds it for its own parameters.
    typedef struct packed {
        logic                 s_a;
        logic                 s_b;
        logic                 c;
        logic [FPU_EXP_W-1:0] e;
        logic [FPU_MAN_W-1:0] m_a;
        logic [FPU_MAN_W-1:0] m_b;
    } operand_t;

    // Special beats carry no class of their own and reuse the last real choice.
    function automatic logic sel_nor(e_data_e cls, logic last_nor);
        case (cls)
            SUBNOR:   return 1'b0;
            NOR, MIX: return 1'b1;
            default:  return last_nor;
        endcase
    endfunction

endpackage

// File: rtl/fpu_add_operand_sel_if.sv
// Handshake and operand bus of the operand-select stage; slave is the stage's view.
interface fpu_add_operand_sel_if
    import fpu_add_pkg::*;
#(
    parameter int unsigned EXP_W = FPU_EXP_W,
    parameter int unsigned MAN_W = FPU_MAN_W
);
    logic             in_valid;
    logic             in_ready;
    logic             nor_sa;
    logic             nor_sb;
    logic             sub_sa;
    logic             sub_sb;
    logic             comp_nor;
    logic             comp_sub;
    logic [EXP_W-1:0] nor_e;
    logic [EXP_W-1:0] sub_e;
    logic [MAN_W-1:0] nor_ma;
    logic [MAN_W-1:0] nor_mb;
    logic [MAN_W-1:0] sub_ma;
    logic [MAN_W-1:0] sub_mb;
    logic [1:0]       e_data;
    logic             out_valid;
    logic             out_ready;
    logic             s_a;
    logic             s_b;
    logic             c;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m_a;
    logic [MAN_W-1:0] m_b;
    logic             sel_err;

    modport master (
        output in_valid, nor_sa, nor_sb, sub_sa, sub_sb, comp_nor, comp_sub,
               nor_e, sub_e, nor_ma, nor_mb, sub_ma, sub_mb, e_data, out_ready,
        input  in_ready, out_valid, s_a, s_b, c, e, m_a, m_b, sel_err
    );

    modport slave (
        input  in_valid, nor_sa, nor_sb, sub_sa, sub_sb, comp_nor, comp_sub,
               nor_e, sub_e, nor_ma, nor_mb, sub_ma, sub_mb, e_data, out_ready,
        output in_ready, out_valid, s_a, s_b, c, e, m_a, m_b, sel_err
    );

endinterface

// File: rtl/fpu_skid_buf.sv
// Registered valid/ready buffer. FPU_ADD_SEL_SKID_EN selects a 2-entry skid with registered
// in_ready; otherwise a single output register with combinational in_ready.
module fpu_skid_buf #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             valid_q;
    logic             accept;
    logic             consume;

    assign consume = valid_q && out_ready;

`ifdef FPU_ADD_SEL_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = din;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d = din;
                end else if (accept) begin
                    skid_d  = din;
                    state_d = TWO;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // Older beat sits in main; the skid beat follows it out.
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
        end
    end
`else
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (accept) begin
            main_d  = din;
            state_d = ONE;
        end else if (consume) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_d != EMPTY);
        end
    end

    assign out_valid = valid_q;
    assign dout      = main_q;

endmodule

// File: rtl/fpu_add_operand_sel.sv
// Picks normal- or subnormal-path operands by data class and registers them through
// fpu_skid_buf. Optional skid buffer: FPU_ADD_SEL_SKID_EN.
module fpu_add_operand_sel
    import fpu_add_pkg::*;
#(
    parameter int unsigned EXP_W = FPU_EXP_W,
    parameter int unsigned MAN_W = FPU_MAN_W
) (
    input logic                  clk,
    input logic                  rst,
    fpu_add_operand_sel_if.slave bus
);
    typedef struct packed {
        logic             s_a;
        logic             s_b;
        logic             c;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m_a;
        logic [MAN_W-1:0] m_b;
    } op_t;

    localparam int unsigned PAY_W = $bits(op_t) + 1;

    logic             last_nor_q;
    logic             take_nor;
    logic             is_special;
    logic             accept;
    op_t              op_in;
    op_t              op_out;
    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    assign is_special = (e_data_e'(bus.e_data) == SPECIAL);
    assign take_nor   = sel_nor(e_data_e'(bus.e_data), last_nor_q);
    assign accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        op_in.s_a = take_nor ? bus.nor_sa   : bus.sub_sa;
        op_in.s_b = take_nor ? bus.nor_sb   : bus.sub_sb;
        op_in.c   = take_nor ? bus.comp_nor : bus.comp_sub;
        op_in.e   = take_nor ? bus.nor_e    : bus.sub_e;
        op_in.m_a = take_nor ? bus.nor_ma   : bus.sub_ma;
        op_in.m_b = take_nor ? bus.nor_mb   : bus.sub_mb;
    end

    assign pay_in = {is_special, op_in};

    // Only real classes update the remembered path; special beats just borrow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_nor_q <= 1'b1;
        end else if (accept && !is_special) begin
            last_nor_q <= take_nor;
        end
    end

    fpu_skid_buf #(
        .WIDTH(PAY_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .din      (pay_in),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .dout     (pay_out)
    );

    assign {bus.sel_err, op_out} = pay_out;
    assign bus.s_a = op_out.s_a;
    assign bus.s_b = op_out.s_b;
    assign bus.c   = op_out.c;
    assign bus.e   = op_out.e;
    assign bus.m_a = op_out.m_a;
    assign bus.m_b = op_out.m_b;

endmodule

// File: tb/tb_fpu_add_operand_sel.sv
// Directed self-checking bench for fpu_add_operand_sel; valid with or without
// FPU_ADD_SEL_SKID_EN.
module tb_fpu_add_operand_sel;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic acc;
    logic b_taken;
    logic m_nor;

    fpu_add_operand_sel_if #(.EXP_W(8), .MAN_W(28)) bus ();

    fpu_add_operand_sel #(.EXP_W(8), .MAN_W(28)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; acceptance is sampled at the falling edge.
    task automatic tick(output logic accepted);
        @(negedge clk);
        accepted = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] ed, input logic [7:0] kk);
        bus.e_data   = ed;
        bus.nor_sa   = kk[0];
        bus.nor_sb   = kk[1];
        bus.comp_nor = kk[2];
        bus.sub_sa   = !kk[0];
        bus.sub_sb   = !kk[1];
        bus.comp_sub = !kk[2];
        bus.nor_e    = kk;
        bus.sub_e    = ~kk;
        bus.nor_ma   = {20'h10000, kk};
        bus.nor_mb   = {20'h20000, kk};
        bus.sub_ma   = {20'h30000, kk};
        bus.sub_mb   = {20'h40000, kk};
    endtask

    function automatic logic [66:0] gen_word(input logic [7:0] kk, input logic nor_path);
        if (nor_path) return {kk[0], kk[1], kk[2], kk, {20'h10000, kk}, {20'h20000, kk}};
        return {!kk[0], !kk[1], !kk[2], ~kk, {20'h30000, kk}, {20'h40000, kk}};
    endfunction

    function automatic logic [66:0] out_word();
        return {bus.s_a, bus.s_b, bus.c, bus.e, bus.m_a, bus.m_b};
    endfunction

    task automatic send_one(input logic [1:0] ed, input logic [7:0] kk);
        set_fields(ed, kk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick(acc);
        bus.in_valid = 1'b0;
    endtask

    task automatic stream_test();
        logic [67:0] exp_q[$];
        logic [67:0] exp_v;
        logic        cons;
        logic        nor_path;
        logic        err;
        logic [1:0]  ed;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        bus.out_ready = 1'b1;
        ed = 2'd0;
        set_fields(ed, 8'd0);
        bus.in_valid = 1'b1;
        while (got < 100 && cyc < 300) begin
            @(negedge clk);
            acc  = bus.in_valid && bus.in_ready;
            cons = bus.out_valid && bus.out_ready;
            if (cons) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_spurious", {bus.sel_err, out_word()}, 68'h0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_eq("stream_beat", {bus.sel_err, out_word()}, exp_v);
                end
                got++;
            end
            if (acc) begin
                ed = sent[1:0];
                if (ed == 2'b11) begin
                    nor_path = m_nor;
                    err      = 1'b1;
                end else begin
                    nor_path = (ed != 2'b00);
                    m_nor    = nor_path;
                    err      = 1'b0;
                end
                exp_q.push_back({err, gen_word(sent[7:0], nor_path)});
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (sent < 100) begin
                ed = sent[1:0];
                set_fields(ed, sent[7:0]);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check_eq("stream_count", got, 100);
        check_eq("stream_cycles", cyc, 101);
        check_eq("stream_left", exp_q.size(), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_nor    = 1'b1;
        rst      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(2'b01, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_sel_err", bus.sel_err, 0);
        check_eq("rst_word", out_word(), 67'h0);

        // Normal class, one-cycle latency
        send_one(2'b01, 8'h85);
        check_eq("nor_accept", acc, 1);
        check_eq("nor_out_valid", bus.out_valid, 1);
        check_eq("nor_e", bus.e, 8'h85);
        check_eq("nor_sel_err", bus.sel_err, 0);

        // Subnormal class picks sub_ma
        set_fields(2'b00, 8'h03);
        bus.sub_ma    = 28'h0000123;
        bus.nor_ma    = 28'hFFFFFFF;
        bus.in_valid  = 1'b1;
        tick(acc);
        bus.in_valid = 1'b0;
        check_eq("sub_m_a", bus.m_a, 28'h0000123);
        check_eq("sub_sel_err", bus.sel_err, 0);

        // Special after subnormal reuses subnormal path
        send_one(2'b11, 8'h05);
        check_eq("spec_after_sub_word", out_word(), gen_word(8'h05, 1'b0));
        check_eq("spec_after_sub_err", bus.sel_err, 1);
        tick(acc);
        check_eq("drain_empty", bus.out_valid, 0);

        // Back-pressure: two beats offered while out_ready is low for 3 cycles
        set_fields(2'b01, 8'd10);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick(acc);
        check_eq("stall_a_accept", acc, 1);
        set_fields(2'b00, 8'd11);
        tick(acc);
        b_taken = acc;
`ifdef FPU_ADD_SEL_SKID_EN
        check_eq("stall_b_accept", acc, 1);
`else
        check_eq("stall_b_held_off", acc, 0);
`endif
        if (acc) bus.in_valid = 1'b0;
        check_eq("stall_in_ready1", bus.in_ready, 0);
        check_eq("stall_hold1", out_word(), gen_word(8'd10, 1'b1));
        tick(acc);
        b_taken = b_taken | acc;
        check_eq("stall_in_ready2", bus.in_ready, 0);
        check_eq("stall_hold2", out_word(), gen_word(8'd10, 1'b1));
        check_eq("stall_valid2", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick(acc);
        b_taken = b_taken | acc;
        bus.in_valid = 1'b0;
        check_eq("stall_b_taken", b_taken, 1);
        check_eq("stall_b_valid", bus.out_valid, 1);
        check_eq("stall_b_word", {bus.sel_err, out_word()}, {1'b0, gen_word(8'd11, 1'b0)});
        tick(acc);
        check_eq("stall_drained", bus.out_valid, 0);

        // Fill up with subnormal beats, then reset over a live handshake
        bus.out_ready = 1'b0;
        set_fields(2'b00, 8'd20);
        bus.in_valid = 1'b1;
        tick(acc);
        set_fields(2'b00, 8'd21);
        tick(acc);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        set_fields(2'b01, 8'd22);
        tick(acc);
        check_eq("rst2_out_valid", bus.out_valid, 0);
        check_eq("rst2_word", out_word(), 67'h0);
        check_eq("rst2_sel_err", bus.sel_err, 0);
        check_eq("rst2_in_ready", bus.in_ready, 1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick(acc);
        check_eq("rst2_nothing_taken", bus.out_valid, 0);

        // Special straight after reset uses the normal path
        send_one(2'b11, 8'd7);
        check_eq("spec_after_rst_valid", bus.out_valid, 1);
        check_eq("spec_after_rst_word", out_word(), gen_word(8'd7, 1'b1));
        check_eq("spec_after_rst_err", bus.sel_err, 1);
        tick(acc);

        // Streaming with remembered path back at normal
        rst = 1'b1;
        tick(acc);
        rst   = 1'b0;
        m_nor = 1'b1;
        stream_test();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
